// File: rtl/sdram_bus_pkg.sv
// Shared definitions for the active-low Avalon-style SDRAM bus: bus widths,
// the responder state encoding and a lane-enable to bit-mask helper.
package sdram_bus_pkg;

  localparam int BUS_ADDR_W = 25;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STALL     = 2'd1,
    READ_PEND = 2'd2,
    RESP      = 2'd3
  } resp_state_t;

  // Expand active-low byte enables into a full-width bit mask (1 = lane written).
  function automatic logic [BUS_DATA_W-1:0] be_mask(input logic [BUS_DATA_W/8-1:0] byte_enable_n);
    logic [BUS_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BUS_DATA_W/8; i++) begin
      m[i*8 +: 8] = {8{~byte_enable_n[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/resp_byte_ram.sv
// Single-port word array with per-byte-lane write enables, synchronous write
// and a registered, enable-gated read port. The array itself is never reset;
// only the read register clears so the bus sees zero data after reset.
module resp_byte_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                we,
  input  logic [DATA_W/8-1:0] lane_we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Commit the enabled byte lanes of a write.
  always_ff @(posedge Clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Capture a word only when asked, and hold it until the next read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// Responder end of the active-low Avalon-style SDRAM bus, backed by an
// on-chip array. Programmable stall before acceptance and read latency;
// one outstanding transaction at a time.
//
// Handshake: a command (read_n=0 or write_n=0) is accepted at the rising
// edge that ends a cycle in which wait_req=0; the master holds the command
// stable until then. A read's data is returned with valid=1 for exactly one
// cycle, READ_LATENCY cycles after its acceptance edge; writes never pulse
// valid. The command the master still presents during the valid cycle
// belongs to that response and is not a new request.
module avalon_mem_responder import sdram_bus_pkg::*; #(
  parameter int ADDR_W       = BUS_ADDR_W,
  parameter int DATA_W       = BUS_DATA_W,
  parameter int MEM_ADDR_W   = 10,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                read_n,
  input  logic                write_n,
  input  logic [DATA_W/8-1:0] byte_enable_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  output logic                wait_req,
  output logic                valid,
  output logic [DATA_W-1:0]   read_data
);

  localparam logic [3:0] STALL_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [3:0] LAT_LOAD   = 4'(READ_LATENCY - 1);

  resp_state_t           state, state_nxt;
  logic [3:0]            stall_cnt, stall_cnt_nxt;
  logic [3:0]            lat_cnt, lat_cnt_nxt;
  logic [MEM_ADDR_W-1:0] idx_q;
  logic                  req, is_read, accept;
  logic                  ram_we, ram_re;
  logic [MEM_ADDR_W-1:0] ram_addr;
  logic                  addr_unused;

  // Read has priority when both strobes are low.
  assign req     = ~read_n | ~write_n;
  assign is_read = ~read_n;

  // Upper address bits alias onto the array and are deliberately ignored.
  assign addr_unused = ^address[ADDR_W-1:MEM_ADDR_W];

  // State, counters and the captured word index.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      lat_cnt   <= '0;
      idx_q     <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      lat_cnt   <= lat_cnt_nxt;
      if (accept) idx_q <= address[MEM_ADDR_W-1:0];
    end
  end

  // Next state, counter updates and the acceptance decision.
  // lat_cnt is loaded with READ_LATENCY-1 and READ_PEND leaves when the
  // decremented count reaches zero, so RESP lands READ_LATENCY cycles
  // after the acceptance edge.
  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    lat_cnt_nxt   = lat_cnt;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            accept = 1'b1;
          end else begin
            state_nxt     = STALL;
            stall_cnt_nxt = STALL_LOAD;
          end
        end
      end
      STALL: begin
        if (!req)                  state_nxt     = IDLE;
        else if (stall_cnt != '0)  stall_cnt_nxt = stall_cnt - 4'd1;
        else                       accept        = 1'b1;
      end
      READ_PEND: begin
        lat_cnt_nxt = lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      if (is_read) begin
        lat_cnt_nxt = LAT_LOAD;
        state_nxt   = (READ_LATENCY == 1) ? RESP : READ_PEND;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Bus strobes and array controls decoded from state and counters.
  // With a one-cycle latency the word is captured at the acceptance edge;
  // otherwise it is captured on the last READ_PEND edge from the held index
  // (nothing else can be accepted in between, so the word is the same).
  always_comb begin
    wait_req = 1'b0;
    valid    = 1'b0;
    case (state)
      IDLE:      wait_req = req && (WAIT_CYCLES != 0);
      STALL:     wait_req = (stall_cnt != '0);
      READ_PEND: wait_req = 1'b1;
      RESP:      valid    = 1'b1;
      default:   wait_req = 1'b1;
    endcase
    if (Reset) wait_req = 1'b1;
    ram_we   = accept && !is_read && !Reset;
    ram_re   = !Reset && ((accept && is_read && (READ_LATENCY == 1)) ||
                          (state == READ_PEND && lat_cnt == 4'd1));
    ram_addr = (state == READ_PEND) ? idx_q : address[MEM_ADDR_W-1:0];
  end

  resp_byte_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .Clk     (Clk),
    .Reset   (Reset),
    .we      (ram_we),
    .lane_we (~byte_enable_n),
    .re      (ram_re),
    .addr    (ram_addr),
    .wdata   (write_data),
    .rdata   (read_data)
  );

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: directed bus scenarios followed by random
// reads/writes against a word-array model; read results go through an
// expected queue checked by an independent monitor.
module tb_avalon_mem_responder;

  localparam int ADDR_W       = 25;
  localparam int DATA_W       = 32;
  localparam int MEM_ADDR_W   = 10;
  localparam int WAIT_CYCLES  = 1;
  localparam int READ_LATENCY = 2;
  localparam int BUDGET       = 40;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              read_n, write_n;
  logic [3:0]        byte_enable_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              wait_req, valid;
  logic [DATA_W-1:0] read_data;

  logic [DATA_W-1:0] model_mem [2**MEM_ADDR_W];
  logic [DATA_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  avalon_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W),
    .WAIT_CYCLES(WAIT_CYCLES), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .Clk(Clk), .Reset(Reset), .read_n(read_n), .write_n(write_n),
    .byte_enable_n(byte_enable_n), .address(address), .write_data(write_data),
    .wait_req(wait_req), .valid(valid), .read_data(read_data)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a) % (2**MEM_ADDR_W);
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding read.
  always @(negedge Clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        check("read_data", read_data, exp_q.pop_front());
        check("resp_wait_req", 32'(wait_req), 32'd0);
      end
    end
  end

  // Waits for the cycle in which wait_req is low; the next rising edge accepts.
  task automatic wait_accept(input string tag);
    int  stalls = 0;
    bit  done = 0;
    for (int c = 0; c < BUDGET && !done; c++) begin
      @(negedge Clk);
      if (wait_req) stalls++;
      else          done = 1;
    end
    check({tag, "_accept_timeout"}, 32'(done), 32'd1);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(WAIT_CYCLES));
  endtask

  task automatic idle_bus();
    read_n        = 1'b1;
    write_n       = 1'b1;
    address       = ADDR_W'($urandom);
    write_data    = $urandom;
    byte_enable_n = 4'($urandom);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [3:0] ben);
    int k;
    read_n = 1'b1; write_n = 1'b0; address = a; write_data = d; byte_enable_n = ben;
    wait_accept("wr");
    @(posedge Clk); #1;
    idle_bus();
    k = idx_of(a);
    for (int i = 0; i < 4; i++) begin
      if (!ben[i]) model_mem[k][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input bit both_low);
    int lat = 0;
    bit got = 0;
    exp_q.push_back(model_mem[idx_of(a)]);
    read_n = 1'b0; write_n = both_low ? 1'b0 : 1'b1; address = a;
    write_data = $urandom; byte_enable_n = 4'($urandom);
    wait_accept("rd");
    @(posedge Clk); #1;
    for (int c = 0; c < BUDGET && !got; c++) begin
      @(negedge Clk);
      lat++;
      if (valid) got = 1;
      else       check("rd_pend_wait_req", 32'(wait_req), 32'd1);
    end
    check("rd_valid_timeout", 32'(got), 32'd1);
    check("rd_latency", 32'(lat), 32'(READ_LATENCY));
    @(posedge Clk); #1;
    idle_bus();
  endtask

  // Command held for one cycle only, then dropped before it can be accepted.
  task automatic withdraw(input bit is_write, input logic [ADDR_W-1:0] a);
    read_n = is_write; write_n = ~is_write; address = a;
    write_data = $urandom; byte_enable_n = 4'b0000;
    @(negedge Clk);
    check("wd_stalled", 32'(wait_req), 32'd1);
    @(posedge Clk); #1;
    idle_bus();
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check("wd_idle_wait_req", 32'(wait_req), 32'd0);
      check("wd_no_valid", 32'(valid), 32'd0);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int op;
    Reset = 1'b1;
    idle_bus();

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_wait_req", 32'(wait_req), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_wait_req", 32'(wait_req), 32'd0);
    @(posedge Clk); #1;

    // Full write, read back, partial write, read back
    do_write(25'h0000005, 32'hDEADBEEF, 4'b0000);
    do_read(25'h0000005, 1'b0);
    do_write(25'h0000005, 32'h11223344, 4'b1100);
    check("model_partial", model_mem[5], 32'hDEAD3344);
    do_read(25'h0000005, 1'b0);

    // Fill a small working set (skipping index 5)
    for (int i = 0; i < 16; i++) begin
      if (i != 5) do_write(ADDR_W'(i), $urandom, 4'b0000);
    end

    // Both strobes low: read wins, aliased address 0x400 -> index 0
    do_read(25'h0000400, 1'b1);
    do_read(25'h0000000, 1'b0);

    // Withdrawn read and write leave memory untouched
    withdraw(1'b0, 25'h0000003);
    withdraw(1'b1, 25'h0000003);
    do_read(25'h0000003, 1'b0);

    // Reset while a read is pending: discarded, read_data cleared
    read_n = 1'b0; write_n = 1'b1; address = 25'h0000005;
    wait_accept("rstrd");
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rstrd_pend_wait_req", 32'(wait_req), 32'd1);
    #1 Reset = 1'b1;
    #1;
    check("rstrd_read_data", read_data, 32'd0);
    check("rstrd_wait_req", 32'(wait_req), 32'd1);
    repeat (3) begin
      @(negedge Clk);
      check("rstrd_no_valid", 32'(valid), 32'd0);
    end
    idle_bus();
    Reset = 1'b0;
    @(posedge Clk); #1;
    do_read(25'h0000005, 1'b0);

    // Random traffic over aliased addresses of the working set
    for (int n = 0; n < 60; n++) begin
      a  = ADDR_W'($urandom_range(0, 15)) | ADDR_W'($urandom_range(0, 3) << MEM_ADDR_W);
      op = $urandom_range(0, 3);
      case (op)
        0:       do_write(a, $urandom, 4'($urandom));
        1:       do_read(a, 1'b0);
        2:       do_read(a, 1'b1);
        default: begin
          repeat ($urandom_range(1, 3)) @(posedge Clk);
          #1;
        end
      endcase
    end

    // Drain
    for (int c = 0; c < BUDGET && exp_q.size() != 0; c++) @(negedge Clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
